// File: rtl/i2c_led_host_pkg.sv
// Shared types and constants for the I2C LED write host.
// State encodings, direction bit and the default target address.
package i2c_led_host_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ACK,
    ST_LOAD,
    ST_DATA,
    ST_STOP
  } state_t;

  localparam logic       I2C_WRITE       = 1'b0;
  localparam logic [6:0] DEFAULT_ADDRESS = 7'h4A;

  function automatic logic [7:0] addr_byte(
    input logic [6:0] addr
  );
    return {addr, I2C_WRITE};
  endfunction

endpackage

// File: rtl/i2c_quarter_timer.sv
// Quarter-bit divider for the I2C host.
// Freezes while stalled or while a target stretches SCL high phases.
module i2c_quarter_timer #(
  parameter int CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       hold,
  input  logic       scl_i,
  output logic       tick,
  output logic       mid,
  output logic [1:0] quarter
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2 - 1);

  logic [CW-1:0] cnt;
  logic          run;

  // Q2/Q3 are the SCL-high quarters; a low pad there is a stretch.
  assign run  = en & ~hold & ~(quarter[1] & ~scl_i);
  assign tick = run & (cnt == LAST);
  assign mid  = run & (quarter == 2'd3) & (cnt == HALF);

  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      cnt     <= '0;
      quarter <= 2'd0;
    end else if (tick) begin
      cnt     <= '0;
      quarter <= quarter + 2'd1;
    end else if (run) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_led_host.sv
// Single-master I2C write host streaming LED bytes to the bridge.
// START, address+W, N acked data bytes from a valid/ready stream, STOP.
module i2c_led_host
  import i2c_led_host_pkg::*;
#(
  parameter logic [6:0] ADDRESS = DEFAULT_ADDRESS,
  parameter int         CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] tdata,
  input  logic       tvalid,
  input  logic       tlast,
  output logic       tready,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_o,
  output logic       sda_o,
  output logic       busy,
  output logic       done,
  output logic       nack
);

  state_t     state;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic       last_byte;
  logic       nacked;
  logic       tick;
  logic       mid;
  logic [1:0] quarter;
  logic       stall;

  assign stall = (state == ST_LOAD);

  i2c_quarter_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (busy),
    .hold    (stall),
    .scl_i   (scl_i),
    .tick    (tick),
    .mid     (mid),
    .quarter (quarter)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      shreg     <= 8'h00;
      bit_cnt   <= 3'd0;
      last_byte <= 1'b0;
      nacked    <= 1'b0;
      scl_o     <= 1'b1;
      sda_o     <= 1'b1;
      busy      <= 1'b0;
      tready    <= 1'b0;
      done      <= 1'b0;
      nack      <= 1'b0;
    end else begin
      tready <= 1'b0;
      done   <= 1'b0;
      nack   <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_START;
            busy      <= 1'b1;
            nacked    <= 1'b0;
            last_byte <= 1'b0;
          end
        end
        ST_START: begin
          if (tick) begin
            case (quarter)
              2'd1: sda_o <= 1'b0;
              2'd3: begin
                scl_o   <= 1'b0;
                shreg   <= addr_byte(ADDRESS);
                bit_cnt <= 3'd0;
                state   <= ST_ADDR;
              end
              default: ;
            endcase
          end
        end
        ST_ADDR, ST_DATA: begin
          if (tick) begin
            case (quarter)
              2'd0: sda_o <= shreg[7];
              2'd1: scl_o <= 1'b1;
              2'd3: begin
                scl_o   <= 1'b0;
                shreg   <= {shreg[6:0], 1'b0};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7)
                  state <= ST_ACK;
              end
              default: ;
            endcase
          end
        end
        ST_ACK: begin
          if (mid && sda_i) begin
            nacked <= 1'b1;
            nack   <= 1'b1;
          end
          if (tick) begin
            case (quarter)
              2'd0: sda_o <= 1'b1;
              2'd1: scl_o <= 1'b1;
              2'd3: begin
                scl_o <= 1'b0;
                if (nacked || last_byte)
                  state <= ST_STOP;
                else
                  state <= ST_LOAD;
              end
              default: ;
            endcase
          end
        end
        ST_LOAD: begin
          // SCL stays low here; the timer is frozen until a byte lands.
          if (tready) begin
            if (tvalid) begin
              shreg     <= tdata;
              last_byte <= tlast;
              bit_cnt   <= 3'd0;
              state     <= ST_DATA;
            end
          end else if (tvalid) begin
            tready <= 1'b1;
          end
        end
        ST_STOP: begin
          if (tick) begin
            case (quarter)
              2'd0: sda_o <= 1'b0;
              2'd1: scl_o <= 1'b1;
              2'd3: begin
                sda_o <= 1'b1;
                busy  <= 1'b0;
                done  <= ~nacked;
                state <= ST_IDLE;
              end
              default: ;
            endcase
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_led_host.sv
// Scoreboard bench for i2c_led_host with an open-drain target model.
// Wire events decoded by the target are checked against a queue.
module tb_i2c_led_host;

  localparam int CLK_DIV  = 4;
  localparam int EV_START = 256;
  localparam int EV_STOP  = 257;
  localparam int EV_ACK   = 258;
  localparam int EV_NACK  = 259;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] tdata = 8'h00;
  logic       tvalid = 1'b0;
  logic       tlast = 1'b0;
  logic       tready, scl_o, sda_o;
  logic       busy, done, nack;
  logic       t_scl_hold = 1'b0;
  logic       t_sda_low = 1'b0;
  logic       scl_pad, sda_pad;

  assign scl_pad = scl_o & ~t_scl_hold;
  assign sda_pad = sda_o & ~t_sda_low;

  int         errors = 0;
  int         checks = 0;
  int         exp_q[$];
  logic [7:0] txb[4];
  bit         nack_addr = 0;
  bit         stretch_en = 0;
  int         stall_idx = -1;
  int         stall_cyc = 0;
  int         cyc = 0;
  int         tready_cnt = 0;
  int         done_cnt = 0;
  int         nack_cnt = 0;
  int         max_low = 0;
  int         st_period = -1;

  logic       ps = 1'b1, pd = 1'b1, s, d;
  int         bitn = 0, bidx = 0;
  logic [7:0] sh = 8'h00;
  bit         active = 0;
  int         fall_cyc = 0, st_cnt = 0, st_fall = 0;
  bit         st_on = 0, st_meas = 0;

  always #5 clk = ~clk;

  i2c_led_host #(
    .ADDRESS (7'h4A),
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .tdata  (tdata),
    .tvalid (tvalid),
    .tlast  (tlast),
    .tready (tready),
    .scl_i  (scl_pad),
    .sda_i  (sda_pad),
    .scl_o  (scl_o),
    .sda_o  (sda_o),
    .busy   (busy),
    .done   (done),
    .nack   (nack)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic sb_event(input int ev);
    int e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL wire_event: got %0d expected none", ev);
    end else begin
      e = exp_q.pop_front();
      chk("wire_event", ev, e);
    end
  endtask

  // Target model and monitor: decodes the bus, ACKs, stretches.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      s = scl_pad;
      d = sda_pad;
      if (tready) tready_cnt++;
      if (done) done_cnt++;
      if (nack) nack_cnt++;
      if (!rst_n) begin
        active = 0;
        bitn = 0;
        t_sda_low = 1'b0;
        t_scl_hold = 1'b0;
        st_on = 0;
        st_meas = 0;
      end else if (ps && s && pd && !d) begin
        sb_event(EV_START);
        active = 1;
        bitn = 0;
        bidx = 0;
      end else if (ps && s && !pd && d) begin
        sb_event(EV_STOP);
        active = 0;
      end else if (active && !ps && s) begin
        if (cyc - fall_cyc > max_low) max_low = cyc - fall_cyc;
        if (bitn < 8) begin
          sh = {sh[6:0], d};
          bitn++;
        end else if (bitn == 8) begin
          sb_event(d ? EV_NACK : EV_ACK);
          bitn = 9;
        end
      end else if (active && ps && !s) begin
        fall_cyc = cyc;
        if (st_meas) begin
          st_period = cyc - st_fall;
          st_meas = 0;
        end
        if (bitn == 3 && bidx == 1 && stretch_en) begin
          t_scl_hold = 1'b1;
          st_on = 1;
          st_cnt = 0;
          st_fall = cyc;
          st_meas = 1;
        end
        if (bitn == 8) begin
          sb_event({24'b0, sh});
          t_sda_low = !(nack_addr && bidx == 0);
          bidx++;
        end else if (bitn == 9) begin
          t_sda_low = 1'b0;
          bitn = 0;
        end
      end
      // Hold SCL low for 20 host edges after the host releases it.
      if (st_on && scl_o) begin
        st_cnt++;
        if (st_cnt == 21) begin
          t_scl_hold = 1'b0;
          st_on = 0;
        end
      end
      ps = s;
      pd = d;
    end
  end

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic feeder(input int n);
    bit got;
    for (int i = 0; i < n; i++) begin
      if (i == stall_idx) begin
        repeat (stall_cyc) @(posedge clk);
        #1;
      end
      tdata = txb[i];
      tlast = (i == n - 1);
      tvalid = 1'b1;
      got = 0;
      while (!got && busy) begin
        @(negedge clk);
        if (tready) got = 1;
      end
      if (got) begin
        @(posedge clk);
        #1;
      end
      tvalid = 1'b0;
      tlast = 1'b0;
      if (!got) break;
    end
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy && k < 20000) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: busy=1 expected 0", tag);
    end
  endtask

  task automatic txn(input string tag, input int n,
                     input bit na, input bit restart);
    exp_q.push_back(EV_START);
    exp_q.push_back(32'h94);
    exp_q.push_back(na ? EV_NACK : EV_ACK);
    if (!na) begin
      for (int i = 0; i < n; i++) begin
        exp_q.push_back({24'b0, txb[i]});
        exp_q.push_back(EV_ACK);
      end
    end
    exp_q.push_back(EV_STOP);
    tready_cnt = 0;
    done_cnt = 0;
    nack_cnt = 0;
    max_low = 0;
    st_period = -1;
    nack_addr = na;
    pulse_start();
    chk({tag, "_busy_up"}, busy, 1);
    fork
      feeder(n);
      wait_idle(tag);
      if (restart) begin
        repeat (100) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
    join
    repeat (5) @(posedge clk);
    #1;
    chk({tag, "_tready"}, tready_cnt, na ? 0 : n);
    chk({tag, "_done"}, done_cnt, na ? 0 : 1);
    chk({tag, "_nack"}, nack_cnt, na ? 1 : 0);
    chk({tag, "_busy_down"}, busy, 0);
    chk({tag, "_events_left"}, exp_q.size(), 0);
    nack_addr = 0;
  endtask

  initial begin
    repeat (4) @(posedge clk);
    #1;
    chk("rst_scl", scl_o, 1);
    chk("rst_sda", sda_o, 1);
    chk("rst_busy", busy, 0);
    chk("rst_tready", tready, 0);
    chk("rst_done", done, 0);
    chk("rst_nack", nack, 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    txb[0] = 8'hFF; txb[1] = 8'h00; txb[2] = 8'h80;
    txn("basic", 3, 0, 0);

    txb[0] = 8'h33;
    txn("addr_nack", 1, 1, 0);

    txb[0] = 8'hA5;
    stretch_en = 1;
    txn("stretch", 1, 0, 0);
    stretch_en = 0;
    // Normal bit is 4 quarters of CLK_DIV plus 20 stretched clocks.
    chk("stretch_period", st_period, 4 * CLK_DIV + 20);

    txb[0] = 8'h11; txb[1] = 8'h22;
    stall_idx = 1;
    stall_cyc = 200;
    txn("stall", 2, 0, 0);
    stall_idx = -1;
    chk("stall_scl_low", max_low >= 50, 1);

    exp_q.push_back(EV_START);
    exp_q.push_back(32'h94);
    exp_q.push_back(EV_ACK);
    txb[0] = 8'h3C;
    pulse_start();
    feeder(1);
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_scl", scl_o, 1);
    chk("midrst_sda", sda_o, 1);
    chk("midrst_busy", busy, 0);
    rst_n = 1'b1;
    chk("midrst_events_left", exp_q.size(), 0);
    repeat (10) @(posedge clk);
    txn("after_rst", 1, 0, 0);

    txb[0] = 8'h5A;
    txn("restart", 1, 0, 1);
    repeat (60) @(posedge clk);
    #1;
    chk("restart_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
